// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) on an open-drain SDA/SCL bus.
//
// Oversamples SDA and SCL on clk_50 through a 2-FF synchronizer and a FILT-sample
// glitch filter, decodes START / repeated START / STOP, a 7-bit address plus R/W,
// an 8-bit sub-address (register pointer) and data bytes. Writes and reads reach
// a local register bank through one-cycle strobes; the pointer auto-increments
// (8-bit wrap) so multi-byte bursts work in both directions. No clock stretching.
//
// Ports:
//   clk_50   in    system clock
//   reset    in    asynchronous, active-high reset
//   SDA      inout open-drain data line (driven 0 or released)
//   SCL      inout open-drain clock line, observed only
//   wr_en    out   one-cycle write strobe, wr_addr/wr_data valid with it
//   wr_addr  out   register address of the write
//   wr_data  out   write data byte
//   rd_req   out   one-cycle read request for the byte at rd_addr
//   rd_addr  out   register address of the read
//   rd_data  in    read data, sampled the cycle after rd_req
//   busy     out   high from an addressed START until STOP or address mismatch
//   error    out   one-cycle pulse on START/STOP in the middle of a byte

module i2c_target #(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned FILT     = 3
) (
  input  logic       clk_50,
  input  logic       reset,
  inout  wire        SDA,
  inout  wire        SCL,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_req,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       error
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StSub,
    StSubAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } state_e;

  // ---------------------------------------------------------------------------
  // Input path: bit 0 = SCL, bit 1 = SDA
  // ---------------------------------------------------------------------------
  logic [1:0]    line_raw;
  logic [1:0]    sync1_q, sync2_q, filt_q, prev_q;
  logic [CW-1:0] fcnt_q [2];

  assign line_raw = {SDA, SCL};

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      filt_q  <= 2'b11;
      prev_q  <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
    end else begin
      sync1_q <= line_raw;
      sync2_q <= sync1_q;
      prev_q  <= filt_q;
      for (int i = 0; i < 2; i++) begin
        // The filtered value only follows after FILT consecutive differing samples.
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == CW'(FILT - 1)) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_ev, stop_ev;

  assign scl_f    = filt_q[0];
  assign sda_f    = filt_q[1];
  assign scl_p    = prev_q[0];
  assign sda_p    = prev_q[1];
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_ev = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_ev  = scl_f & scl_p & ~sda_p & sda_f;

  // ---------------------------------------------------------------------------
  // Protocol FSM
  // ---------------------------------------------------------------------------
  state_e     state_q;
  logic [2:0] bit_cnt_q;   // completed bits (rise+fall pairs) of the current byte
  logic       half_q;      // a rise was seen, its closing fall is still pending
  logic       ack_phase_q; // in an ACK state: SDA is already held low for the ACK bit
  logic [7:0] shift_q;
  logic [7:0] ptr_q;
  logic       rw_q;
  logic       mack_q;      // master ACK/NACK sampled after a read byte
  logic       load_q;      // rd_data is valid this cycle
  logic       sda_oe_q;

  logic       in_bits;
  assign in_bits = (state_q == StAddr) || (state_q == StSub) ||
                   (state_q == StWdata) || (state_q == StRdata);

  assign SDA = sda_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      half_q      <= 1'b0;
      ack_phase_q <= 1'b0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      mack_q      <= 1'b1;
      load_q      <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      busy        <= 1'b0;
      error       <= 1'b0;
    end else begin
      wr_en  <= 1'b0;
      rd_req <= 1'b0;
      error  <= 1'b0;

      if (start_ev || stop_ev) begin
        // Bus conditions override any bit processing in the same cycle.
        if (in_bits && (bit_cnt_q != 3'd0)) error <= 1'b1;
        sda_oe_q    <= 1'b0;
        bit_cnt_q   <= '0;
        half_q      <= 1'b0;
        ack_phase_q <= 1'b0;
        load_q      <= 1'b0;
        if (start_ev) begin
          state_q <= StAddr;
        end else begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      end else if (load_q) begin
        // First bit of a read byte goes out as soon as rd_data is available.
        load_q    <= 1'b0;
        shift_q   <= rd_data;
        sda_oe_q  <= ~rd_data[7];
        bit_cnt_q <= '0;
        half_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StAddr: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_f};
              half_q  <= 1'b1;
              if (bit_cnt_q == 3'd7) begin
                if (shift_q[6:0] == DEV_ADDR) begin
                  busy    <= 1'b1;
                  rw_q    <= sda_f;
                  state_q <= StAddrAck;
                end else begin
                  busy    <= 1'b0;
                  state_q <= StIgnore;
                end
              end
            end else if (scl_fall && half_q) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              half_q    <= 1'b0;
            end
          end

          StAddrAck: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= 1'b1;
                ack_phase_q <= 1'b1;
              end else begin
                sda_oe_q    <= 1'b0;
                ack_phase_q <= 1'b0;
                bit_cnt_q   <= '0;
                half_q      <= 1'b0;
                if (rw_q) begin
                  rd_req  <= 1'b1;
                  rd_addr <= ptr_q;
                  load_q  <= 1'b1;
                  state_q <= StRdata;
                end else begin
                  state_q <= StSub;
                end
              end
            end
          end

          StSub: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_f};
              half_q  <= 1'b1;
              if (bit_cnt_q == 3'd7) begin
                ptr_q   <= {shift_q[6:0], sda_f};
                state_q <= StSubAck;
              end
            end else if (scl_fall && half_q) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              half_q    <= 1'b0;
            end
          end

          StSubAck: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= 1'b1;
                ack_phase_q <= 1'b1;
              end else begin
                sda_oe_q    <= 1'b0;
                ack_phase_q <= 1'b0;
                bit_cnt_q   <= '0;
                half_q      <= 1'b0;
                state_q     <= StWdata;
              end
            end
          end

          StWdata: begin
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], sda_f};
              half_q  <= 1'b1;
              if (bit_cnt_q == 3'd7) begin
                wr_en   <= 1'b1;
                wr_addr <= ptr_q;
                wr_data <= {shift_q[6:0], sda_f};
                state_q <= StWdataAck;
              end
            end else if (scl_fall && half_q) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              half_q    <= 1'b0;
            end
          end

          StWdataAck: begin
            if (scl_fall) begin
              if (!ack_phase_q) begin
                sda_oe_q    <= 1'b1;
                ack_phase_q <= 1'b1;
              end else begin
                sda_oe_q    <= 1'b0;
                ack_phase_q <= 1'b0;
                bit_cnt_q   <= '0;
                half_q      <= 1'b0;
                ptr_q       <= ptr_q + 8'd1;
                state_q     <= StWdata;
              end
            end
          end

          StRdata: begin
            // The master samples the current MSB on the rise; the next bit goes out
            // on the following fall.
            if (scl_rise) begin
              shift_q <= {shift_q[6:0], 1'b0};
              half_q  <= 1'b1;
            end else if (scl_fall && half_q) begin
              half_q <= 1'b0;
              if (bit_cnt_q == 3'd7) begin
                sda_oe_q <= 1'b0;
                state_q  <= StRdataAck;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                sda_oe_q  <= ~shift_q[7];
              end
            end
          end

          StRdataAck: begin
            if (scl_rise) begin
              mack_q <= sda_f;
            end else if (scl_fall) begin
              if (!mack_q) begin
                ptr_q     <= ptr_q + 8'd1;
                rd_addr   <= ptr_q + 8'd1;
                rd_req    <= 1'b1;
                load_q    <= 1'b1;
                bit_cnt_q <= '0;
                half_q    <= 1'b0;
                state_q   <= StRdata;
              end else begin
                state_q <= StIgnore;
              end
            end
          end

          StIdle, StIgnore: begin
            sda_oe_q <= 1'b0;
          end

          default: begin
            sda_oe_q <= 1'b0;
            state_q  <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master drives the bus, expected
// register-bank strobes are queued up front and a negedge monitor pops and
// compares them (plus queued master-side observations) as the DUT responds.

module tb_i2c_target;

  localparam int Q = 12;  // clk_50 cycles per quarter SCL period

  logic       clk_50 = 1'b0;
  logic       reset;
  logic       m_sda_low, m_scl_low;
  wire        sda_bus, scl_bus;
  logic       wr_en, rd_req, busy, error;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] mem [256];

  always #10 clk_50 = ~clk_50;

  assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
  assign scl_bus = m_scl_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  pullup (scl_bus);

  assign rd_data = mem[rd_addr];

  i2c_target #(
    .DEV_ADDR(7'h1A),
    .FILT    (3)
  ) dut (
    .clk_50 (clk_50),
    .reset  (reset),
    .SDA    (sda_bus),
    .SCL    (scl_bus),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_req (rd_req),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy   (busy),
    .error  (error)
  );

  // Scoreboard queues
  string       pend_name [$];
  logic [15:0] pend_act  [$];
  logic [15:0] pend_exp  [$];
  logic [15:0] exp_wr    [$];
  logic [7:0]  exp_rd    [$];

  int checks   = 0;
  int failures = 0;
  int err_cnt  = 0;
  int low_cnt  = 0;

  string       mon_n;
  logic [15:0] mon_a, mon_e;
  logic [7:0]  mon_r;

  // Monitor: every comparison happens here, away from the active edge.
  always @(negedge clk_50) begin
    while (pend_name.size() > 0) begin
      mon_n = pend_name.pop_front();
      mon_a = pend_act.pop_front();
      mon_e = pend_exp.pop_front();
      checks++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h", mon_n, mon_a, mon_e);
      end
    end
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h, expected no write",
                 wr_addr, wr_data);
      end else begin
        mon_e = exp_wr.pop_front();
        if ({wr_addr, wr_data} !== mon_e) begin
          failures++;
          $display("FAIL wr_strobe: got addr/data 0x%0h, expected 0x%0h",
                   {wr_addr, wr_data}, mon_e);
        end
      end
    end
    if (rd_req === 1'b1) begin
      checks++;
      if (exp_rd.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected: got addr 0x%0h, expected no read", rd_addr);
      end else begin
        mon_r = exp_rd.pop_front();
        if (rd_addr !== mon_r) begin
          failures++;
          $display("FAIL rd_strobe: got addr 0x%0h, expected 0x%0h", rd_addr, mon_r);
        end
      end
    end
    if (error === 1'b1) err_cnt++;
    if (!m_sda_low && sda_bus === 1'b0) low_cnt++;
  end

  task automatic expect_eq(input string n, input logic [15:0] a, input logic [15:0] e);
    pend_name.push_back(n);
    pend_act.push_back(a);
    pend_exp.push_back(e);
  endtask

  function automatic logic sda_val();
    return (sda_bus === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic wq();
    repeat (Q) @(posedge clk_50);
  endtask

  // START (or repeated START); leaves SCL low.
  task automatic bus_start();
    m_sda_low = 1'b0; wq();
    m_scl_low = 1'b0; wq();
    m_sda_low = 1'b1; wq();
    m_scl_low = 1'b1; wq();
  endtask

  // STOP from SCL low; leaves the bus idle.
  task automatic bus_stop();
    m_sda_low = 1'b1; wq();
    m_scl_low = 1'b0; wq();
    m_sda_low = 1'b0; wq();
    wq();
  endtask

  task automatic wr_bit(input logic b, input logic glitch);
    m_sda_low = ~b; wq();
    m_scl_low = 1'b0; wq();
    if (glitch) begin
      m_scl_low = 1'b1;
      @(posedge clk_50);
      m_scl_low = 1'b0;
    end
    wq();
    m_scl_low = 1'b1; wq();
  endtask

  task automatic rd_bit(output logic b);
    m_sda_low = 1'b0; wq();
    m_scl_low = 1'b0; wq();
    b = sda_val(); wq();
    m_scl_low = 1'b1; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch, output logic ack);
    for (int i = 7; i >= 0; i--) wr_bit(d[i], i == glitch);
    rd_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rd_bit(b);
      d = {d[6:0], b};
    end
    wr_bit(~mack, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    expect_eq({tag, "_sda"}, 16'(sda_val()), 16'h1);
    expect_eq({tag, "_strobes"}, 16'({busy, wr_en, rd_req, error}), 16'h0);
    expect_eq({tag, "_wr_bus"}, {wr_addr, wr_data}, 16'h0);
    expect_eq({tag, "_rd_addr"}, 16'(rd_addr), 16'h0);
  endtask

  task automatic write_burst(input string tag);
    logic a;
    int   e0;
    e0 = err_cnt;
    exp_wr.push_back(16'h10A5);
    exp_wr.push_back(16'h115A);
    bus_start();
    write_byte(8'h34, -1, a); expect_eq({tag, "_ack_addr"}, 16'(a), 16'h0);
    expect_eq({tag, "_busy_on"}, 16'(busy), 16'h1);
    write_byte(8'h10, -1, a); expect_eq({tag, "_ack_sub"}, 16'(a), 16'h0);
    write_byte(8'hA5, -1, a); expect_eq({tag, "_ack_d0"}, 16'(a), 16'h0);
    write_byte(8'h5A, -1, a); expect_eq({tag, "_ack_d1"}, 16'(a), 16'h0);
    bus_stop();
    expect_eq({tag, "_busy_off"}, 16'(busy), 16'h0);
    expect_eq({tag, "_err"}, 16'(err_cnt - e0), 16'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    logic       a;
    logic [7:0] d;
    int         e0, l0;
    logic [7:0] sub;

    reset     = 1'b1;
    m_sda_low = 1'b0;
    m_scl_low = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'hFE] = 8'hC3;
    mem[8'hFF] = 8'h81;
    mem[8'h00] = 8'h5E;
    repeat (4) @(posedge clk_50);
    #1;
    check_idle("reset");
    @(posedge clk_50);
    reset = 1'b0;
    wq();

    // Write burst
    write_burst("wb");

    // Combined read with pointer wrap
    e0 = err_cnt;
    exp_rd.push_back(8'hFE);
    exp_rd.push_back(8'hFF);
    exp_rd.push_back(8'h00);
    bus_start();
    write_byte(8'h34, -1, a); expect_eq("rd_ack_addr_w", 16'(a), 16'h0);
    write_byte(8'hFE, -1, a); expect_eq("rd_ack_sub", 16'(a), 16'h0);
    bus_start();
    write_byte(8'h35, -1, a); expect_eq("rd_ack_addr_r", 16'(a), 16'h0);
    read_byte(d, 1'b1); expect_eq("rd_byte0", 16'(d), 16'h00C3);
    read_byte(d, 1'b1); expect_eq("rd_byte1", 16'(d), 16'h0081);
    read_byte(d, 1'b0); expect_eq("rd_byte2", 16'(d), 16'h005E);
    l0 = low_cnt;
    repeat (4) wq();
    bus_stop();
    expect_eq("rd_released_after_nack", 16'(low_cnt - l0), 16'h0);
    expect_eq("rd_busy_off", 16'(busy), 16'h0);
    expect_eq("rd_err", 16'(err_cnt - e0), 16'h0);

    // Address mismatch
    l0 = low_cnt;
    bus_start();
    write_byte(8'h36, -1, a); expect_eq("mm_nack", 16'(a), 16'h1);
    expect_eq("mm_busy", 16'(busy), 16'h0);
    bus_stop();
    expect_eq("mm_busy_after", 16'(busy), 16'h0);
    expect_eq("mm_sda_never_low", 16'(low_cnt - l0), 16'h0);

    // Protocol error: START three bits into the sub-address
    e0 = err_cnt;
    exp_wr.push_back(16'h2011);
    bus_start();
    write_byte(8'h34, -1, a); expect_eq("pe_ack_addr0", 16'(a), 16'h0);
    sub = 8'h20;
    for (int i = 7; i >= 5; i--) wr_bit(sub[i], 1'b0);
    bus_start();
    write_byte(8'h34, -1, a); expect_eq("pe_ack_addr1", 16'(a), 16'h0);
    write_byte(8'h20, -1, a); expect_eq("pe_ack_sub", 16'(a), 16'h0);
    write_byte(8'h11, -1, a); expect_eq("pe_ack_data", 16'(a), 16'h0);
    bus_stop();
    expect_eq("pe_err_once", 16'(err_cnt - e0), 16'h1);

    // One-cycle SCL glitch during the address phase
    e0 = err_cnt;
    exp_wr.push_back(16'h0577);
    bus_start();
    write_byte(8'h34, 4, a); expect_eq("gl_ack_addr", 16'(a), 16'h0);
    write_byte(8'h05, -1, a); expect_eq("gl_ack_sub", 16'(a), 16'h0);
    write_byte(8'h77, -1, a); expect_eq("gl_ack_data", 16'(a), 16'h0);
    bus_stop();
    expect_eq("gl_err", 16'(err_cnt - e0), 16'h0);

    // Async reset while the sub-address ACK is being driven
    bus_start();
    write_byte(8'h34, -1, a); expect_eq("rs_ack_addr", 16'(a), 16'h0);
    sub = 8'h10;
    for (int i = 7; i >= 0; i--) wr_bit(sub[i], 1'b0);
    m_sda_low = 1'b0; wq();
    m_scl_low = 1'b0; wq();
    expect_eq("rs_sub_ack_low", 16'(sda_val()), 16'h0);
    reset = 1'b1;
    #1;
    check_idle("rs_mid");
    @(posedge clk_50);
    m_scl_low = 1'b1; wq();
    reset = 1'b0; wq();
    bus_stop();
    write_burst("wb2");

    wq();
    expect_eq("wr_left", 16'(exp_wr.size()), 16'h0);
    expect_eq("rd_left", 16'(exp_rd.size()), 16'h0);
    repeat (3) @(posedge clk_50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) that answers the team's I2C master transactions on the same open-drain SDA/SCL bus.
- Oversamples SDA/SCL on clk_50 and decodes START, repeated START, STOP, the 7-bit address, an 8-bit sub-address and data bytes.
- Presents writes and reads to a local register bank through a simple strobe interface.
- Sub-address auto-increments, so multi-byte bursts work in both directions.

Parameters:
- DEV_ADDR, 7'h1A, 7-bit bus address this target ACKs.
- FILT, 3, number of consecutive clk_50 samples a synchronized line must hold before the filtered value changes (glitch filter).

Ports:
- clk_50  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-high reset.
- SDA  inout  1  open-drain data line; driven 0 or released to Z.
- SCL  inout  1  open-drain clock line; never driven (no clock stretching); observed only.
- wr_en  output  1  one-cycle pulse; wr_addr/wr_data valid in the same cycle.
- wr_addr  output  8  register address for the write.
- wr_data  output  8  write data byte.
- rd_req  output  1  one-cycle pulse requesting the byte at rd_addr.
- rd_addr  output  8  register address for the read.
- rd_data  input  8  read data; must be valid the cycle after rd_req and is sampled exactly then.
- busy  output  1  high from an addressed START until STOP or an address mismatch.
- error  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset values, async: SDA released, wr_en=0, wr_addr=0, wr_data=0, rd_req=0, rd_addr=0, busy=0, error=0, pointer=0, state=IDLE.
- Input path: 2-FF synchronizer on each line, then the FILT-sample filter.
- Edge events come from filtered values only:
  - scl_rise, scl_fall.
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
- Bit timing: sample SDA on scl_rise; change the driven SDA only on scl_fall (SDA never changes while SCL high).
- States:
  - IDLE
  - ADDR (8 bits: 7 address + R/W)
  - ADDR_ACK
  - SUB (8 bits)
  - SUB_ACK
  - WDATA (8 bits)
  - WDATA_ACK
  - RDATA (8 bits driven, MSB first)
  - RDATA_ACK (master ACK/NACK)
  - IGNORE
- START from any state: go to ADDR, bit count=0. busy is not set yet.
- ADDR complete (8th scl_rise):
  - Address ≠ DEV_ADDR: go to IGNORE (SDA released) until the next START or STOP.
  - Match: set busy; pull SDA low on the next scl_fall for the ACK bit.
  - R/W=0: after the ACK bit, go to SUB.
  - R/W=1: rd_req pulses on the scl_fall that ends the ACK bit, with rd_addr=pointer; rd_data is latched into the shift register the following cycle; go to RDATA.
- SUB complete: pointer ← byte; ACK; go to WDATA.
- WDATA complete:
  - wr_en pulses for one cycle after the 8th scl_rise, with wr_addr=pointer and wr_data=byte.
  - ACK, then pointer increments.
  - A further byte stays in WDATA; a repeated START goes to ADDR; STOP goes to IDLE.
- RDATA: drive the shift-register MSB on each scl_fall (0 → drive low, 1 → release). After 8 bits, release SDA and go to RDATA_ACK.
- RDATA_ACK: sample SDA on scl_rise.
  - ACK (0): pointer increments; on scl_fall, pulse rd_req with the new pointer and reload; continue in RDATA.
  - NACK (1): keep SDA released; go to IGNORE and wait for STOP.
- STOP in any state: release SDA, busy=0, go to IDLE; the pointer is retained.
- Pointer arithmetic is 8-bit wrap: 0xFF+1 = 0x00.
- Error: pulse for one cycle when START or STOP arrives with bit count 1..7 inside ADDR, SUB, WDATA or RDATA. The FSM then follows the normal START/STOP transition.
- Simultaneous events: START/STOP take precedence over bit processing in the same cycle.
- Reset mid-transfer returns to IDLE immediately and releases SDA; the next bus START is decoded normally.
- Latency: wr_en pulses no later than 2 clk_50 cycles after the filtered 8th scl_rise of a data byte.

Test Plan:
- Write burst: START, 0x34 (addr 0x1A, W), sub 0x10, data 0xA5, 0x5A, STOP.
  - Required: ACK on all four bytes.
  - wr_en pulses twice: (0x10, 0xA5), then (0x11, 0x5A).
  - busy falls at STOP.
- Combined read: START, 0x34, sub 0xFE, repeated START, 0x35; master ACKs 2 bytes then NACKs the 3rd.
  - rd_req addresses must be 0xFE, 0xFF, 0x00 (wrap).
  - SDA must carry the rd_data values MSB first.
  - After the NACK, SDA is released until STOP.
- Address mismatch: START, 0x36, STOP.
  - SDA never driven.
  - No wr_en/rd_req.
  - busy stays 0.
- Protocol error: START, 0x34, then START after 3 bits of the sub-address.
  - error pulses once.
  - The following 0x34, sub 0x20, data 0x11, STOP writes (0x20, 0x11).
- Glitch: a 1-cycle SCL low pulse while SCL is high during the address phase.
  - No bit is counted.
  - The transfer completes correctly.
- Async reset mid-write (after the sub-address ACK):
  - SDA released immediately.
  - All outputs return to reset values.
  - The next transaction behaves as in the write-burst case.
